// File: rtl/step_ctrl.sv
// Front-panel execution controller: debounces the next/run/speedRun buttons and
// issues single-cycle CPU step strobes for single-step, slow-run and fast-run modes.
module step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned SLOW_DIV        = 25_000_000,
  parameter int unsigned FAST_DIV        = 50_000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next,
  input  logic        run,
  input  logic        speedRun,
  input  logic        edit,
  input  logic        halt,
  output logic        step,
  output logic [1:0]  mode,
  output logic [15:0] step_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN_SLOW = 2'b01,
    RUN_FAST = 2'b10,
    HALTED   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

  state_t           state;
  logic [2:0]       raw, sync1, sync2, stable, prev, press;
  logic [CNT_W-1:0] db_cnt [3];
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] div_last;

  // Bit order for all button vectors: 0 = next, 1 = run, 2 = speedRun.
  assign raw      = {speedRun, run, next};
  assign mode     = state;
  assign div_last = (state == RUN_SLOW) ? SLOW_LAST : FAST_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      prev   <= '0;
      press  <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= stable;
      press <= stable & ~prev;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= ~stable[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CNT_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Presses are consumed by whichever branch handles them; anything else that
  // arrives in the same cycle is dropped, giving speedRun > run > next.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div        <= '0;
      step       <= 1'b0;
      step_count <= '0;
    end else begin
      step <= 1'b0;
      if (edit) begin
        state <= IDLE;
        div   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!halt) begin
              if (press[2]) begin
                state <= RUN_FAST;
                div   <= '0;
              end else if (press[1]) begin
                state <= RUN_SLOW;
                div   <= '0;
              end else if (press[0]) begin
                step       <= 1'b1;
                step_count <= step_count + 16'd1;
              end
            end
          end
          RUN_SLOW, RUN_FAST: begin
            if (halt) begin
              state <= HALTED;
              div   <= '0;
            end else if (press[2]) begin
              state <= (state == RUN_SLOW) ? RUN_FAST : RUN_SLOW;
              div   <= '0;
            end else if (press[1]) begin
              state <= IDLE;
              div   <= '0;
            end else if (div == div_last) begin
              div        <= '0;
              step       <= 1'b1;
              step_count <= step_count + 16'd1;
            end else begin
              div <= div + CNT_W'(1);
            end
          end
          HALTED: begin
            if (!halt && (|press)) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl: directed scenarios plus random button/halt/edit traffic,
// all compared each cycle against a behavioural model of the panel rules.
module tb_step_ctrl;

  localparam int D  = 4;
  localparam int SD = 10;
  localparam int FD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, next = 1'b0, run = 1'b0, speed_run = 1'b0, edit = 1'b0, halt = 1'b0;
  logic step;
  logic [1:0] mode;
  logic [15:0] step_count;

  logic rst2 = 1'b1, sr2 = 1'b0, zero = 1'b0;
  logic step2;
  logic [1:0] mode2;
  logic [15:0] step_count2;

  step_ctrl #(.DEBOUNCE_CYCLES(D), .SLOW_DIV(SD), .FAST_DIV(FD), .CNT_W(25)) dut (
    .clk(clk), .rst(rst), .next(next), .run(run), .speedRun(speed_run),
    .edit(edit), .halt(halt), .step(step), .mode(mode), .step_count(step_count)
  );

  // Every-cycle stepping instance so the 16-bit counter wrap is reachable quickly.
  step_ctrl #(.DEBOUNCE_CYCLES(D), .SLOW_DIV(SD), .FAST_DIV(1), .CNT_W(25)) dut_wrap (
    .clk(clk), .rst(rst2), .next(zero), .run(zero), .speedRun(sr2),
    .edit(zero), .halt(zero), .step(step2), .mode(mode2), .step_count(step_count2)
  );

  int passed = 0;
  int total  = 0;
  int nsteps = 0;

  // Model: button b has sync stages, accepted level, run length of disagreeing samples.
  int m_s1[3], m_s2[3], m_stab[3], m_runlen[3], m_prev[3], m_press[3];
  int m_mode = 0, m_div = 0, m_step = 0, m_count = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic fire();
    m_step  = 1;
    m_count = (m_count + 1) % 65536;
  endtask

  task automatic model_edge();
    int p[3];
    logic [2:0] r;
    r = {speed_run, run, next};
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_stab[b] = 0; m_runlen[b] = 0; m_prev[b] = 0; m_press[b] = 0;
      end
      m_mode = 0; m_div = 0; m_step = 0; m_count = 0;
      return;
    end
    p = m_press;
    for (int b = 0; b < 3; b++) begin
      m_press[b] = (m_stab[b] == 1 && m_prev[b] == 0) ? 1 : 0;
      m_prev[b]  = m_stab[b];
      if (m_s2[b] != m_stab[b]) begin
        m_runlen[b]++;
        if (m_runlen[b] == D) begin
          m_stab[b]   = 1 - m_stab[b];
          m_runlen[b] = 0;
        end
      end else begin
        m_runlen[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = int'(r[b]);
    end
    m_step = 0;
    if (edit) begin
      m_mode = 0; m_div = 0;
    end else if (m_mode == 0) begin
      if (!halt) begin
        if (p[2] == 1) m_mode = 2;
        else if (p[1] == 1) m_mode = 1;
        else if (p[0] == 1) fire();
      end
    end else if (m_mode == 3) begin
      if (!halt && (p[0] + p[1] + p[2]) > 0) m_mode = 0;
    end else begin
      if (halt) begin
        m_mode = 3; m_div = 0;
      end else if (p[2] == 1) begin
        m_mode = 3 - m_mode; m_div = 0;
      end else if (p[1] == 1) begin
        m_mode = 0; m_div = 0;
      end else begin
        m_div++;
        if (m_div == ((m_mode == 1) ? SD : FD)) begin
          m_div = 0;
          fire();
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("step", {31'b0, step}, m_step);
    chk("mode", {30'b0, mode}, m_mode);
    chk("count", {16'b0, step_count}, m_count);
    if (step === 1'b1) nsteps++;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int first;
    int found;
    hold(2);
    chk("reset_mode", {30'b0, mode}, 0);
    chk("reset_count", {16'b0, step_count}, 0);
    rst = 1'b0;

    // Held next: exactly one step, 7 cycles after the first high edge.
    next = 1'b1; nsteps = 0; first = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (step === 1'b1 && first < 0) first = k;
    end
    next = 1'b0;
    hold(10);
    chk("next_latency", first, 7);
    chk("next_one_step", nsteps, 1);
    chk("next_count", {16'b0, step_count}, 1);

    // Bouncing next never settles long enough to be accepted.
    nsteps = 0;
    for (int k = 0; k < 12; k++) begin
      next = (k % 2 == 0);
      tick();
    end
    next = 1'b0;
    hold(10);
    chk("bounce_steps", nsteps, 0);
    chk("bounce_count", {16'b0, step_count}, 1);

    // Slow run: steps every 10 cycles, second run press returns to idle.
    run = 1'b1; hold(8); run = 1'b0;
    nsteps = 0; hold(35);
    chk("slow_mode", {30'b0, mode}, 1);
    chk("slow_steps", nsteps, 3);
    run = 1'b1; hold(8); run = 1'b0; hold(4);
    chk("slow_stop", {30'b0, mode}, 0);

    // Slow -> fast, halt, then a press leaves HALTED without stepping.
    run = 1'b1; hold(8); run = 1'b0; hold(5);
    speed_run = 1'b1; hold(8); speed_run = 1'b0;
    nsteps = 0; hold(12);
    chk("fast_mode", {30'b0, mode}, 2);
    chk("fast_steps", nsteps, 4);
    halt = 1'b1; nsteps = 0; hold(5);
    chk("halt_mode", {30'b0, mode}, 3);
    chk("halt_steps", nsteps, 0);
    halt = 1'b0; next = 1'b1; hold(8); next = 1'b0; hold(3);
    chk("unhalt_mode", {30'b0, mode}, 0);
    chk("unhalt_steps", nsteps, 0);

    // Edit while fast-running, with a run press landing inside the edit window.
    speed_run = 1'b1; hold(8); speed_run = 1'b0; hold(4);
    run = 1'b1; hold(3);
    edit = 1'b1; nsteps = 0; hold(5); edit = 1'b0;
    chk("edit_steps", nsteps, 0);
    chk("edit_mode", {30'b0, mode}, 0);
    run = 1'b0; hold(10);
    chk("edit_after", {30'b0, mode}, 0);

    // Reset in RUN_FAST with the divider at 2.
    speed_run = 1'b1; hold(8); speed_run = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (m_div == 2 && m_mode == 2) begin found = 1; break; end
      tick();
    end
    chk("div2_reached", found, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mode", {30'b0, mode}, 0);
    chk("rst_step", {31'b0, step}, 0);
    chk("rst_count", {16'b0, step_count}, 0);

    // Random panel traffic.
    for (int seg = 0; seg < 200; seg++) begin
      next      = ($urandom_range(0, 3) == 0);
      run       = ($urandom_range(0, 4) == 0);
      speed_run = ($urandom_range(0, 5) == 0);
      halt      = ($urandom_range(0, 7) == 0);
      edit      = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 60) == 0);
      hold($urandom_range(1, 12));
    end
    {next, run, speed_run, halt, edit, rst} = '0;
    hold(10);

    // Counter wrap on the every-cycle instance.
    rst2 = 1'b0; sr2 = 1'b1; found = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (step2 === 1'b1) begin found = 1; break; end
    end
    chk("wrap_started", found, 1);
    chk("wrap_first", {16'b0, step_count2}, 1);
    repeat (65534) @(negedge clk);
    chk("wrap_ffff", {16'b0, step_count2}, 32'hFFFF);
    @(negedge clk);
    chk("wrap_zero", {16'b0, step_count2}, 0);
    chk("wrap_mode", {30'b0, mode2}, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
